// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, edge/bit counting, checker strobes and data_valid.
// Define UART_RX_ERR_CNT_EN to add the saturating err_cnt output.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  data_samp_en,
    output logic                  strt_chk_en,
    output logic                  deser_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [3:0]            LAST_BIT = 4'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] MIN_P    = PRESCALE_W'(8);

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [PRESCALE_W-1:0]   edge_cnt_r;
    logic [PRESCALE_W-1:0]   edge_nx_s;
    logic [PRESCALE_W-1:0]   p_r;
    logic [PRESCALE_W-1:0]   p_nx_s;
    logic [PRESCALE_W-1:0]   chk_s;
    logic [3:0]              bit_cnt_r;
    logic [3:0]              bit_nx_s;
    logic                    pe_r;
    logic                    pe_nx_s;
    logic                    last_edge_s;
    logic                    chk_hit_s;
    logic                    frame_ok_s;

    // Oversampling ratio and parity mode are frozen for the whole frame at start detection.
    assign chk_s       = {1'b0, p_r[PRESCALE_W-1:1]} + PRESCALE_W'(2);
    assign last_edge_s = (edge_cnt_r == (p_r - PRESCALE_W'(1)));
    assign chk_hit_s   = (edge_cnt_r == chk_s);
    assign frame_ok_s  = !stp_err && (!pe_r || !par_err);

    // Next-state, counter advance and strobe decode
    always_comb begin
        state_nx_s   = state_r;
        p_nx_s       = p_r;
        pe_nx_s      = pe_r;
        strt_chk_en  = 1'b0;
        deser_en     = 1'b0;
        par_chk_en   = 1'b0;
        stp_chk_en   = 1'b0;
        data_valid   = 1'b0;
        data_samp_en = (state_r != IDLE);
        if (last_edge_s) begin
            edge_nx_s = '0;
            bit_nx_s  = bit_cnt_r + 4'd1;
        end else begin
            edge_nx_s = edge_cnt_r + PRESCALE_W'(1);
            bit_nx_s  = bit_cnt_r;
        end

        case (state_r)
            IDLE: begin
                edge_nx_s = '0;
                bit_nx_s  = '0;
                if (!RX_IN) begin
                    state_nx_s = START;
                    p_nx_s     = (prescale < MIN_P) ? MIN_P : prescale;
                    pe_nx_s    = PAR_EN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: begin
                strt_chk_en = chk_hit_s;
                if (last_edge_s) begin
                    bit_nx_s   = '0;
                    state_nx_s = strt_glitch ? IDLE : DATA;
                end else begin
                    state_nx_s = START;
                end
            end
            DATA: begin
                deser_en = chk_hit_s;
                if (last_edge_s && (bit_cnt_r == LAST_BIT)) begin
                    state_nx_s = pe_r ? PARITY : STOP;
                end else begin
                    state_nx_s = DATA;
                end
            end
            PARITY: begin
                par_chk_en = chk_hit_s;
                if (last_edge_s) begin
                    state_nx_s = STOP;
                end else begin
                    state_nx_s = PARITY;
                end
            end
            STOP: begin
                stp_chk_en = chk_hit_s;
                data_valid = last_edge_s && frame_ok_s;
                if (last_edge_s) begin
                    bit_nx_s   = '0;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = STOP;
                end
            end
            default: begin
                edge_nx_s  = '0;
                bit_nx_s   = '0;
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, counter and frame-parameter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            edge_cnt_r <= '0;
            bit_cnt_r  <= '0;
            p_r        <= MIN_P;
            pe_r       <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            edge_cnt_r <= edge_nx_s;
            bit_cnt_r  <= bit_nx_s;
            p_r        <= p_nx_s;
            pe_r       <= pe_nx_s;
        end
    end

    assign edge_cnt = edge_cnt_r;
    assign bit_cnt  = bit_cnt_r;

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt_r;
    logic       err_evt_s;

    // A rejected start and a suppressed frame both count as one error.
    assign err_evt_s = last_edge_s &&
                       (((state_r == START) && strt_glitch) ||
                        ((state_r == STOP) && !frame_ok_s));

    // Saturating error counter, cleared only by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_cnt_r <= 8'd0;
        end else if (err_evt_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

endmodule
